// File: rtl/qarctan_pkg.sv
// Shared types and fixed-point constant helpers for the sequential quantized arctan.
package qarctan_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam real PI_REAL = 3.14159265358979323846;

  function automatic int quantize_f_bits(input real value, input int bits);
    real scale;
    scale = 1.0;
    for (int i = 0; i < bits; i++) scale = scale * 2.0;
    return $rtoi(value * scale);
  endfunction

  function automatic real dequantize_bits(input int value, input int bits);
    real scale;
    scale = 1.0;
    for (int i = 0; i < bits; i++) scale = scale * 2.0;
    return $itor(value) / scale;
  endfunction

endpackage

// File: rtl/qarctan_divider.sv
// Unsigned restoring divider producing one quotient bit per cycle, MSB first.
module qarctan_divider
  import qarctan_pkg::*;
#(
  parameter int NUM_W  = 44,
  parameter int DEN_W  = 34,
  parameter int Q_BITS = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [NUM_W-1:0]  numerator,
  input  logic [DEN_W-1:0]  denominator,
  output logic              done,
  output logic [Q_BITS-1:0] quotient
);

  localparam int CW = $clog2(Q_BITS + 1);

  logic [NUM_W-1:0]  rem_q, rem_d;
  logic [NUM_W-1:0]  dsh_q, dsh_d;
  logic [Q_BITS-1:0] quo_q, quo_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  // Load on start, then one compare/subtract step per cycle against a right-shifting divisor.
  always_comb begin
    rem_d = rem_q;
    dsh_d = dsh_q;
    quo_d = quo_q;
    cnt_d = cnt_q;
    if (start) begin
      rem_d = numerator;
      dsh_d = NUM_W'(denominator) << (Q_BITS - 1);
      quo_d = '0;
      cnt_d = CW'(Q_BITS);
    end else if (cnt_q != CW'(0)) begin
      if (rem_q >= dsh_q) begin
        rem_d = rem_q - dsh_q;
        quo_d = {quo_q[Q_BITS-2:0], 1'b1};
      end else begin
        quo_d = {quo_q[Q_BITS-2:0], 1'b0};
      end
      dsh_d = dsh_q >> 1;
      cnt_d = cnt_q - CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rem_q <= '0;
      dsh_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      dsh_q <= dsh_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
    end
  end

  // Final step is in progress: quotient is complete after this edge.
  assign done     = (cnt_q == CW'(1));
  assign quotient = quo_q;

endmodule

// File: rtl/qarctan_seq.sv
// Sequential quantized arctan(y, x) between FIFOs with an iterative divider.
// Define QARCTAN_ROUND_EN to round the final scaling half away from zero instead of truncating.
module qarctan_seq
  import qarctan_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  inA_rd_en,
  input  logic                  inA_empty,
  input  logic [DATA_WIDTH-1:0] inA_dout,
  output logic                  inB_rd_en,
  input  logic                  inB_empty,
  input  logic [DATA_WIDTH-1:0] inB_dout,
  output logic                  out_wr_en,
  input  logic                  out_full,
  output logic [DATA_WIDTH-1:0] out_din,
  output logic                  busy
);

  localparam int IW    = DATA_WIDTH + 2;
  localparam int NW    = IW + FRAC_BITS;
  localparam int QW    = FRAC_BITS + 1;
  localparam int AW    = 2 * FRAC_BITS + 4;
  localparam int QUAD1 = quantize_f_bits(PI_REAL / 4.0, FRAC_BITS);
  localparam int QUAD3 = quantize_f_bits(3.0 * PI_REAL / 4.0, FRAC_BITS);

  state_t               state_q, state_d;
  logic                 num_neg_q, num_neg_d;
  logic                 ysign_q, ysign_d;
  logic signed [AW-1:0] base_q, base_d;

  logic                 pop_s, div_done_s;
  logic [QW-1:0]        quot_s;
  logic signed [IW-1:0] y_s, x_s, abs_y_s, diff_s, den_s;
  logic [IW-1:0]        diff_mag_s;
  logic [NW-1:0]        num_mag_s;
  logic signed [AW-1:0] base_sel_s;
  logic [AW-1:0]        p_mag_s, d_mag_s;
  logic signed [AW-1:0] d_s, angle_s, out_s;
  logic signed [DATA_WIDTH+AW-1:0] out_wide_s;

  // Gating with reset keeps the pops quiet while reset is held, even with data waiting.
  assign pop_s = reset && !inA_empty && !inB_empty &&
                 ((state_q == S_IDLE) || ((state_q == S_OUT) && !out_full));

  // Fold the pair into a quadrant-relative ratio num/den in the widened domain.
  always_comb begin
    y_s     = {{2{inA_dout[DATA_WIDTH-1]}}, inA_dout};
    x_s     = {{2{inB_dout[DATA_WIDTH-1]}}, inB_dout};
    abs_y_s = (y_s[IW-1] ? -y_s : y_s) + signed'(IW'(1));
    if (!x_s[IW-1]) begin
      diff_s     = x_s - abs_y_s;
      den_s      = x_s + abs_y_s;
      base_sel_s = signed'(AW'(QUAD1));
    end else begin
      diff_s     = x_s + abs_y_s;
      den_s      = abs_y_s - x_s;
      base_sel_s = signed'(AW'(QUAD3));
    end
    diff_mag_s = diff_s[IW-1] ? unsigned'(-diff_s) : unsigned'(diff_s);
    num_mag_s  = NW'(diff_mag_s) << FRAC_BITS;
  end

  qarctan_divider #(
    .NUM_W  (NW),
    .DEN_W  (IW),
    .Q_BITS (QW)
  ) u_div (
    .clock       (clock),
    .reset       (reset),
    .start       (pop_s),
    .numerator   (num_mag_s),
    .denominator (den_s),
    .done        (div_done_s),
    .quotient    (quot_s)
  );

  // Next-state and capture logic.
  always_comb begin
    state_d   = state_q;
    num_neg_d = num_neg_q;
    ysign_d   = ysign_q;
    base_d    = base_q;
    if (pop_s) begin
      num_neg_d = diff_s[IW-1];
      ysign_d   = y_s[IW-1];
      base_d    = base_sel_s;
    end else begin
      base_d    = base_q;
    end
    case (state_q)
      S_IDLE:  state_d = pop_s ? S_DIV : S_IDLE;
      S_DIV:   state_d = div_done_s ? S_OUT : S_DIV;
      S_OUT: begin
        if (out_full)   state_d = S_OUT;
        else if (pop_s) state_d = S_DIV;
        else            state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      num_neg_q <= 1'b0;
      ysign_q   <= 1'b0;
      base_q    <= '0;
    end else begin
      state_q   <= state_d;
      num_neg_q <= num_neg_d;
      ysign_q   <= ysign_d;
      base_q    <= base_d;
    end
  end

  // Scale on the magnitude so negative ratios truncate (or round) toward zero symmetrically.
  always_comb begin
    p_mag_s = AW'(QUAD1) * AW'(quot_s);
`ifdef QARCTAN_ROUND_EN
    d_mag_s = (p_mag_s + AW'(1 << (FRAC_BITS - 1))) >> FRAC_BITS;
`else
    d_mag_s = p_mag_s >> FRAC_BITS;
`endif
    d_s        = num_neg_q ? -signed'(d_mag_s) : signed'(d_mag_s);
    angle_s    = base_q - d_s;
    out_s      = ysign_q ? -angle_s : angle_s;
    out_wide_s = {{DATA_WIDTH{out_s[AW-1]}}, out_s};
  end

  assign inA_rd_en = pop_s;
  assign inB_rd_en = pop_s;
  assign out_wr_en = reset && (state_q == S_OUT) && !out_full;
  assign out_din   = (state_q == S_OUT) ? out_wide_s[DATA_WIDTH-1:0] : '0;
  assign busy      = (state_q == S_DIV) || (state_q == S_OUT);

endmodule

// File: doc/qarctan_seq.md
Name: qarctan_seq

Overview:
- Parametrised successor to the single-cycle two-FIFO quantized arctan (FM discriminator angle stage).
- Pops one (y, x) pair from two input FIFOs and computes the quantized qarctan(y, x). The divide is an iterative one-quotient-bit-per-cycle divider, not a combinational divide.
- Pushes the signed angle to an output FIFO.
- Width and fractional precision are parameters. The next pair is accepted in the same cycle the result is written.

Parameters:
- DATA_WIDTH, 32: width of inA_dout (y), inB_dout (x) and out_din. Must be ≥ FRAC_BITS+3.
- FRAC_BITS, 10: fixed-point fraction bits. Sets the quantization scale and the number of divide iterations.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- inA_rd_en  out  1  pop y FIFO.
- inA_empty  in  1  y FIFO empty.
- inA_dout  in  DATA_WIDTH  signed y sample.
- inB_rd_en  out  1  pop x FIFO.
- inB_empty  in  1  x FIFO empty.
- inB_dout  in  DATA_WIDTH  signed x sample.
- out_wr_en  out  1  push angle.
- out_full  in  1  output FIFO full.
- out_din  out  DATA_WIDTH  signed quantized angle.
- busy  out  1  high in S_DIV or S_OUT.

Behaviour:
- Reset: asynchronous assert while reset=0. State=S_IDLE, all registers 0, inA_rd_en=inB_rd_en=out_wr_en=0, out_din=0, busy=0.
- Constants (truncated, as GLOBALS::QUANTIZE_F): QUAD1 = int(pi/4 * 2^FRAC_BITS); QUAD3 = int(3pi/4 * 2^FRAC_BITS). For FRAC_BITS=10: 804 and 2412.
- Internal width is DATA_WIDTH+2 bits throughout, so |y| of the most-negative input and x+abs_y never overflow.
- Capture (pop in S_IDLE, or pop in S_OUT):
  - abs_y = |y|+1.
  - If x≥0: num = (x-abs_y)<<FRAC_BITS, den = x+abs_y, base = QUAD1.
  - Else: num = (x+abs_y)<<FRAC_BITS, den = abs_y-x, base = QUAD3.
  - Register sign(num), |num|, den, base, and ysign = (y<0).
- Division:
  - den ≥ 1 and |num| ≤ den*2^FRAC_BITS, so |r| ≤ 2^FRAC_BITS.
  - Restoring division over quotient bits FRAC_BITS..0, MSB first, one bit per cycle: exactly FRAC_BITS+1 cycles in S_DIV.
  - r = sign(num) applied to the unsigned quotient, i.e. truncation toward zero (C semantics).
- Angle (combinational in S_OUT):
  - p = QUAD1*r, computed at 2*FRAC_BITS+4 bits.
  - d = p/2^FRAC_BITS truncated toward zero; not an arithmetic shift on negatives.
  - angle = base - d. out_din = ysign ? -angle : angle, sign-extended or truncated to DATA_WIDTH.
- State machine:
  - S_IDLE: if !inA_empty && !inB_empty, assert both rd_en for that one cycle, capture, go to S_DIV. Otherwise stay.
  - S_DIV: count FRAC_BITS+1 cycles, then go to S_OUT. Inputs are ignored and no rd_en is asserted.
  - S_OUT: out_din is driven. If !out_full, assert out_wr_en.
    - If both inputs are also non-empty in that cycle, pop and capture the next pair and go to S_DIV.
    - Otherwise go to S_IDLE.
  - S_OUT with out_full: hold out_din stable, no pops, stay.
- Latency: pop at cycle 0 gives out_wr_en at cycle FRAC_BITS+2 at the earliest. Sustained throughput is one result per FRAC_BITS+2 cycles.
- Handshake rules:
  - inA_rd_en and inB_rd_en are always equal.
  - Never pop when either FIFO is empty. One FIFO empty and the other not means wait; nothing is popped.
  - At most one out_wr_en per captured pair.
- Reset mid-operation: an in-flight result is discarded, never written. The FSM returns to S_IDLE.

Optional Feature:
- Macro QARCTAN_ROUND_EN.
- Defined: d = (|p| + 2^(FRAC_BITS-1))/2^FRAC_BITS with the sign of p reapplied, i.e. round half away from zero.
- Undefined: truncation toward zero, bit-exact to the C model.
- Latency and handshakes are identical in both builds.

Decomposition:
- Shared package GLOBALS (existing) gains:
  - QUANTIZE_F_BITS(real, bits) and DEQUANTIZE_BITS(value, bits) function variants taking FRAC_BITS as an argument.
  - PI_REAL is reused.
- Local package qarctan_pkg holds state_t {S_IDLE, S_DIV, S_OUT}.
- One natural sub-module: qarctan_divider, an unsigned restoring divider.
  - Ports: start, numerator, denominator, done, quotient.
  - Parametrised by width and quotient bit count.

Test Plan (DATA_WIDTH=32, FRAC_BITS=10, round undefined unless noted):
- y=0, x=1 -> r=0, out_din=804, out_wr_en exactly 12 cycles after the pop.
- y=5, x=0 -> r=-1024, out_din=1608; y=-5, x=0 -> out_din=-1608.
- y=-100, x=-100 -> r=5, d=3, out_din=-2409.
- y=0, x=100 -> r=1003, out_din=17. With QARCTAN_ROUND_EN -> 16.
- Back-to-back pairs with out_full=0 -> write and next pop in the same cycle, one result per 12 cycles. Hold out_full=1 for 20 cycles -> out_din stable, no pops, no writes. Deassert -> single write.
- Only inA non-empty for 10 cycles -> no rd_en. Assert reset (0) during S_DIV -> no write, S_IDLE, all outputs 0. Input y=-2^31, x=0 -> correct sign-handled result, no overflow.
